// File: rtl/queue_ctrl_if.sv
// Task-side handshake bundle for queue_ctrl: per-task push/pop requests,
// completion strobes and occupancy flags.
interface queue_ctrl_if #(
  parameter int QW = 4
);
  logic          req0;
  logic          req1;
  logic          op0;
  logic          op1;
  logic          ack0;
  logic          ack1;
  logic          err;
  logic [QW-1:0] qp_out;
  logic [1:0]    full;
  logic [1:0]    empty;

  // Task execution logic side
  modport master (
    output req0, req1, op0, op1,
    input  ack0, ack1, err, qp_out, full, empty
  );

  // Controller side
  modport slave (
    input  req0, req1, op0, op1,
    output ack0, ack1, err, qp_out, full, empty
  );
endinterface

// File: rtl/queue_ctrl.sv
// Two-task round-robin arbiter and read-capture-write sequencer for the
// queue_file pointer register file, with per-task occupancy tracking.
module queue_ctrl #(
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          rst,
  queue_ctrl_if.slave   bus,
  output logic          qf_r_ts,
  output logic          qf_rs,
  output logic          qf_w_ts,
  output logic          qf_ws,
  output logic          qf_hold,
  output logic          qf_q_dir,
  output logic [QW-1:0] qf_i_qp,
  input  logic [QW-1:0] qf_o_qp
);

  localparam logic [QW:0]   DEPTH   = {1'b1, {QW{1'b0}}};
  localparam logic [QW:0]   CNT_ONE = {{QW{1'b0}}, 1'b1};
  localparam logic [QW-1:0] PTR_ONE = {{(QW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    WR
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic          tsk;
  logic          opq;
  logic          last;
  logic [QW-1:0] ptr;
  logic          rej;
  logic [QW:0]   cnt0;
  logic [QW:0]   cnt1;
  logic [QW:0]   cnt_sel;

  // Values held on the queue_file write lines between writes
  logic          w_ts_q;
  logic          dir_q;
  logic [QW-1:0] iqp_q;

  logic          start;
  logic          grant;
  logic          ack0;
  logic          ack1;
  logic          err;
  logic [QW-1:0] qp_out;

  assign cnt_sel = tsk ? cnt1 : cnt0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    grant    = 1'b0;
    qf_rs    = 1'b0;
    qf_ws    = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    err      = 1'b0;
    qp_out   = '0;
    qf_w_ts  = w_ts_q;
    qf_q_dir = dir_q;
    qf_i_qp  = iqp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          start   = 1'b1;
          // On a tie the task that was not served last wins
          grant   = (bus.req0 && bus.req1) ? ~last : bus.req1;
          state_d = RD;
        end
      end
      RD: begin
        qf_rs   = 1'b1;
        state_d = CAP;
      end
      CAP: begin
        state_d = WR;
      end
      WR: begin
        ack0   = ~tsk;
        ack1   = tsk;
        err    = rej;
        qp_out = opq ? ptr - PTR_ONE : ptr;
        if (!rej) begin
          qf_ws    = 1'b1;
          qf_w_ts  = tsk;
          qf_q_dir = opq;
          qf_i_qp  = opq ? ptr - PTR_ONE : ptr + PTR_ONE;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tsk    <= 1'b0;
      opq    <= 1'b0;
      last   <= 1'b1;
      ptr    <= '0;
      rej    <= 1'b0;
      cnt0   <= '0;
      cnt1   <= '0;
      w_ts_q <= 1'b0;
      dir_q  <= 1'b0;
      iqp_q  <= '0;
    end else begin
      if (start) begin
        tsk  <= grant;
        opq  <= grant ? bus.op1 : bus.op0;
        last <= grant;
      end
      if (state_q == CAP) begin
        ptr <= qf_o_qp;
        rej <= opq ? (cnt_sel == '0) : (cnt_sel == DEPTH);
      end
      if (qf_ws) begin
        w_ts_q <= qf_w_ts;
        dir_q  <= qf_q_dir;
        iqp_q  <= qf_i_qp;
        if (tsk) cnt1 <= opq ? cnt1 - CNT_ONE : cnt1 + CNT_ONE;
        else     cnt0 <= opq ? cnt0 - CNT_ONE : cnt0 + CNT_ONE;
      end
    end
  end

  assign qf_r_ts    = tsk;
  assign qf_hold    = ~qf_ws;

  assign bus.ack0   = ack0;
  assign bus.ack1   = ack1;
  assign bus.err    = err;
  assign bus.qp_out = qp_out;
  assign bus.full   = {cnt1 == DEPTH, cnt0 == DEPTH};
  assign bus.empty  = {cnt1 == '0, cnt0 == '0};

endmodule

// File: doc/queue_ctrl.md
# queue_ctrl

Sequencing controller and two-task arbiter for the `queue_file` pointer register file. It accepts push/pop requests from task 0 and task 1, grants them round-robin, and runs a fixed read–capture–write sequence on `queue_file`. The sequence reads the task's current queue pointer, steps it up or down, and writes it back. Per-task occupancy is tracked so the block can flag full/empty and reject overflow and underflow. It sits between the task execution logic and `queue_file`; `qp_out` addresses the queue storage.

## Interface
Parameters:
- `QW`, default 4: queue pointer width. Depth per task is `2**QW`.

Ports:
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req0` / `req1`, input, 1: operation request from task 0 / 1. Held high until the matching ack.
- `op0` / `op1`, input, 1: operation, 0 = push, 1 = pop. Stable while the request is high.
- `ack0` / `ack1`, output, 1: one-cycle completion strobe for task 0 / 1.
- `err`, output, 1: qualifies the ack strobe. 1 = operation rejected (overflow or underflow).
- `qp_out`, output, QW: slot pointer of the acked operation. Valid only with an ack.
- `full`, output, 2: bit n = task n occupancy is `2**QW`.
- `empty`, output, 2: bit n = task n occupancy is 0.
- `qf_r_ts`, output, 1: `queue_file` read task select.
- `qf_rs`, output, 1: `queue_file` read select.
- `qf_w_ts`, output, 1: `queue_file` write task select.
- `qf_ws`, output, 1: `queue_file` write select.
- `qf_hold`, output, 1: `queue_file` hold value.
- `qf_q_dir`, output, 1: `queue_file` queue direction, 0 = push, 1 = pop.
- `qf_i_qp`, output, QW: new queue pointer to `queue_file`.
- `qf_o_qp`, input, QW: current queue pointer from `queue_file`. Valid one cycle after `qf_rs`/`qf_r_ts` are presented.

## Operation
The FSM has four states: IDLE, RD, CAP, WR.

**IDLE**
- If no request is pending, stay in IDLE.
- Otherwise pick a task:
  - If only one task requests, grant it.
  - If both request, grant the task that is not `last`.
- Latch the granted task into `tsk` and its op into `opq`. Set `last <= tsk`. Go to RD.

**RD**
- Drive `qf_rs=1` and `qf_r_ts=tsk`. Go to CAP.

**CAP**
- Capture `ptr <= qf_o_qp`.
- Set `rej <= (opq==0 && cnt[tsk]==2**QW) || (opq==1 && cnt[tsk]==0)`.
- Go to WR.

**WR**
- Assert `ack[tsk]=1` and `err=rej`.
- If `rej=0`:
  - Drive `qf_ws=1` and `qf_w_ts=tsk`.
  - Drive `qf_q_dir=opq`.
  - Drive `qf_i_qp` = `ptr+1` for push, `ptr-1` for pop. Arithmetic is modulo `2**QW`, so pointers wrap in both directions.
  - Set `cnt[tsk]` to `±1`.
- If `rej=1`: no write, `cnt` unchanged.
- `qp_out` = `ptr` for push, `ptr-1` (mod `2**QW`) for pop.
- Go to IDLE.

**Output decode and counters**
- `qf_hold = ~qf_ws` in every state.
- When not active, `qf_rs`, `qf_ws`, `ack*` and `err` are 0. Select lines and `qf_i_qp` hold their last value.
- Occupancy counters are `QW+1` bits, one per task, and never leave `0..2**QW`.
- `full` and `empty` are decoded combinationally from the counters.

## Timing
- Latency: a request sampled in IDLE at cycle 0 gives RD in cycle 1, CAP in cycle 2, and ack in cycle 3.
- The controller is back in IDLE in cycle 4 and can sample the next request there. Peak throughput is 1 operation per 4 cycles.
- A request still high in the ack cycle is not treated as new. The next sample happens in IDLE.
- Requests deasserted before ack are protocol violations; the controller completes the latched operation anyway.
- The `queue_file` write takes effect at the WR clock edge. A following RD of the same task sees the updated pointer.
- `full`/`empty` change in the cycle after WR.
- Reset values:
  - FSM state IDLE.
  - `cnt0 = cnt1 = 0`, `last = 1`, so task 0 wins the first tie.
  - `ack0 = ack1 = err = 0`, `qp_out = 0`.
  - `qf_rs = qf_ws = 0`, `qf_hold = 1`.
  - `qf_r_ts = qf_w_ts = qf_q_dir = 0`, `qf_i_qp = 0`.
  - `full = 2'b00`, `empty = 2'b11`.
- Reset in any state aborts the operation: no write, no ack. The `queue_file` contents are not touched.

## Test plan
- **Single push.** After reset, with `qf_o_qp` model = 4'h7: `req0=1, op0=0` → `qf_rs`/`qf_r_ts=0` in cycle 1. In cycle 3: `ack0=1`, `err=0`, `qf_ws=1`, `qf_i_qp=4'h8`, `qp_out=4'h7`. Then `empty=2'b10`.
- **Pop wrap-around.** Task 1 pointer 4'h0, `cnt1=1`, pop → `qf_i_qp=4'hF`, `qf_q_dir=1`, `qp_out=4'hF`, `empty[1]=1` afterwards.
- **Underflow and overflow.** Pop on an empty task 0 → `ack0=1`, `err=1`, `qf_ws` stays 0. After 16 pushes to task 0 → `full=2'b01`; the 17th push returns `err=1`, pointer unchanged.
- **Arbitration fairness.** `req0` and `req1` held high continuously → grants alternate task 0, task 1, task 0, …; an ack every 4 cycles. `qf_w_ts` matches the acked task.
- **Reset mid-operation.** `rst` asserted during CAP → no ack, `qf_ws` never 1, all outputs at their reset values next cycle, counters 0.
